icache_axi_rd_slave: RTL

- AXI4 read-only responder: the slave end of the instruction-cache read channel.
- Accepts AR requests from the ICache miss path and returns burst R beats read from a synchronous single-port instruction SRAM.
- Sits between the ICache master port and the boot/instruction memory, in both the SoC top and the simulation top.
- Supports INCR, WRAP and FIXED bursts, backpressure, and error responses.

---
 rtl/icache_axi_rd_slave.sv | 164 ++++++++++++++++
 1 files changed

// File: rtl/icache_axi_rd_slave.sv
// AXI4 read-only slave between the ICache miss port and a synchronous single-port instruction SRAM.
// One outstanding burst; each beat costs a READ (SRAM strobe) cycle plus a RESP cycle.
module icache_axi_rd_slave #(
    parameter int                ADDR_WIDTH = 32,
    parameter int                DATA_WIDTH = 32,
    parameter int                ID_WIDTH   = 4,
    parameter logic [ADDR_WIDTH-1:0] MEM_BASE = 32'h8000_0000,
    parameter int                MEM_WORDS  = 16384,
    localparam int               MEM_AW     = $clog2(MEM_WORDS)
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  ar_valid,
    output logic                  ar_ready,
    input  logic [ID_WIDTH-1:0]   ar_id,
    input  logic [ADDR_WIDTH-1:0] ar_addr,
    input  logic [7:0]            ar_len,
    input  logic [2:0]            ar_size,
    input  logic [1:0]            ar_burst,
    output logic                  r_valid,
    input  logic                  r_ready,
    output logic [ID_WIDTH-1:0]   r_id,
    output logic [DATA_WIDTH-1:0] r_data,
    output logic [1:0]            r_resp,
    output logic                  r_last,
    output logic                  mem_en,
    output logic [MEM_AW-1:0]     mem_addr,
    input  logic [DATA_WIDTH-1:0] mem_rdata
);

    localparam int DATA_BYTES = DATA_WIDTH / 8;
    localparam int OFF_LSB    = $clog2(DATA_BYTES);
    localparam logic [ADDR_WIDTH:0] MEM_END =
        (ADDR_WIDTH+1)'(MEM_BASE) + (ADDR_WIDTH+1)'(MEM_WORDS * DATA_BYTES);

    typedef enum logic [1:0] {ST_IDLE, ST_READ, ST_RESP} state_t;

    state_t                r_state;
    state_t                w_next;
    logic [ID_WIDTH-1:0]   r_arid;
    logic [ADDR_WIDTH-1:0] r_addr;
    logic [7:0]            r_len;
    logic [2:0]            r_size;
    logic [1:0]            r_burst;
    logic                  r_berr;
    logic [7:0]            r_cnt;
    logic                  r_ok;

    logic                  w_ar_err;
    logic [ADDR_WIDTH-1:0] w_ar_szmask;
    logic                  w_in_range;
    logic [ADDR_WIDTH-1:0] w_off;
    logic [ADDR_WIDTH-1:0] w_szmask;
    logic [ADDR_WIDTH-1:0] w_step;
    logic [ADDR_WIDTH-1:0] w_bmask;
    logic [ADDR_WIDTH-1:0] w_next_addr;
    logic                  w_last;

    // Burst-level legality, evaluated on the raw AR fields at the handshake.
    always_comb begin
        w_ar_szmask = ~({ADDR_WIDTH{1'b1}} << ar_size);
        w_ar_err    = 1'b0;
        if (ar_size > 3'(OFF_LSB))
            w_ar_err = 1'b1;
        if (ar_burst == 2'b11)
            w_ar_err = 1'b1;
        if (ar_burst == 2'b10) begin
            if (!(ar_len inside {8'd1, 8'd3, 8'd7, 8'd15}))
                w_ar_err = 1'b1;
            if ((ar_addr & w_ar_szmask) != '0)
                w_ar_err = 1'b1;
        end
    end

    assign w_in_range = ({1'b0, r_addr} >= {1'b0, MEM_BASE}) && ({1'b0, r_addr} < MEM_END);
    assign w_off      = r_addr - MEM_BASE;
    assign w_last     = (r_cnt == r_len);

    always_comb begin
        w_szmask    = ~({ADDR_WIDTH{1'b1}} << r_size);
        w_step      = ADDR_WIDTH'(1) << r_size;
        w_bmask     = ((ADDR_WIDTH'(r_len) + ADDR_WIDTH'(1)) << r_size) - ADDR_WIDTH'(1);
        w_next_addr = r_addr;
        case (r_burst)
            2'b01:   w_next_addr = (r_addr & ~w_szmask) + w_step;
            2'b10:   w_next_addr = (r_addr & ~w_bmask) | ((r_addr + w_step) & w_bmask);
            default: w_next_addr = r_addr;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst)
            r_state <= ST_IDLE;
        else
            r_state <= w_next;
    end

    always_comb begin
        w_next   = r_state;
        ar_ready = 1'b0;
        r_valid  = 1'b0;
        mem_en   = 1'b0;
        case (r_state)
            ST_IDLE: begin
                ar_ready = rst;
                if (ar_valid && rst)
                    w_next = ST_READ;
            end
            ST_READ: begin
                mem_en = w_in_range && !r_berr;
                w_next = ST_RESP;
            end
            ST_RESP: begin
                r_valid = 1'b1;
                if (r_ready)
                    w_next = w_last ? ST_IDLE : ST_READ;
            end
            default: w_next = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            r_arid  <= '0;
            r_addr  <= '0;
            r_len   <= '0;
            r_size  <= '0;
            r_burst <= '0;
            r_berr  <= 1'b0;
            r_cnt   <= '0;
            r_ok    <= 1'b0;
        end else begin
            case (r_state)
                ST_IDLE: begin
                    if (ar_valid) begin
                        r_arid  <= ar_id;
                        r_addr  <= ar_addr;
                        r_len   <= ar_len;
                        r_size  <= ar_size;
                        r_burst <= ar_burst;
                        r_berr  <= w_ar_err;
                        r_cnt   <= '0;
                    end
                end
                ST_READ: r_ok <= w_in_range && !r_berr;
                ST_RESP: begin
                    if (r_ready && !w_last) begin
                        r_addr <= w_next_addr;
                        r_cnt  <= r_cnt + 8'd1;
                    end
                end
                default: ;
            endcase
        end
    end

    // SRAM data is consumed directly in RESP; it stays put until the next strobe.
    assign mem_addr = (r_state == ST_READ) ? MEM_AW'(w_off >> OFF_LSB) : '0;
    assign r_id     = r_arid;
    assign r_data   = (r_state == ST_RESP && r_ok) ? mem_rdata : '0;
    assign r_resp   = (r_state == ST_RESP && !r_ok) ? 2'b10 : 2'b00;
    assign r_last   = (r_state == ST_RESP) && w_last;

endmodule
